// File: rtl/nf_digital_filter_edge.sv
// nf_digital_filter_edge
//
// Digital back-end for the analog noise-filter input cell. The block takes the
// asynchronous NFOUT level and does the following:
//   1. Synchronises it into the clk domain.
//   2. Passes it through a programmable persistence filter, clocked by a
//      prescaled sample tick. A new level is accepted only after it has been
//      seen on Neff consecutive ticks.
//   3. Produces the clean level, a one-cycle edge pulse and a sticky
//      interrupt flag.
//
// Ports
//   clk        in   1      system clock, all flops rising-edge
//   rst        in   1      synchronous active-high reset
//   en         in   1      block enable (level)
//   nfout_in   in   1      asynchronous level from the analog filter cell
//   prescale   in   PRE_W  sample tick every prescale+1 cycles (0 = every cycle)
//   filt_n     in   CNT_W  consecutive mismatching ticks to accept a change
//                          (0 behaves as 1)
//   edge_sel   in   2      00 none, 01 rising, 10 falling, 11 both
//   clr        in   1      single-cycle clear of irq_flag
//   lvl        out  1      filtered, synchronised level
//   edge_p     out  1      one-cycle pulse, the cycle after lvl changes
//   irq_flag   out  1      sticky edge flag; a set beats a clear in the same cycle
//   state_dbg  out  2      FSM state (0 dis, 1 stable, 2 pend)
//   cnt_dbg    out  CNT_W  filter mismatch count
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.

module nf_digital_filter_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int PRE_W       = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             nfout_in,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] filt_n,
    input  logic [1:0]       edge_sel,
    input  logic             clr,
    output logic             lvl,
    output logic             edge_p,
    output logic             irq_flag,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] cnt_dbg
);

    typedef enum logic [1:0] {
        st_dis    = 2'd0,
        st_stable = 2'd1,
        st_pend   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               s_in;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [CNT_W-1:0]   neff;
    logic [CNT_W:0]     cnt_inc;
    logic               accept;
    logic               mismatch;
    logic               rise_q;
    logic               fall_q;

    // ------------------------------------------------------------------
    // Synchroniser. nfout_in feeds only the first flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], nfout_in};
        end
    end

    assign s_in = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Prescaler. The compare uses the live prescale value. If a new, smaller
    // value leaves the count already past the limit, the next cycle produces
    // a tick and wraps, so the count never runs away to 2**PRE_W.
    // ------------------------------------------------------------------
    assign tick = en && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Filter arithmetic. The count is widened by one bit so that cnt+1 cannot
    // wrap. Using >= rather than == means a count stranded above a newly
    // lowered filt_n still accepts on the next mismatching tick.
    // ------------------------------------------------------------------
    assign neff     = (filt_n == '0) ? CNT_W'(1) : filt_n;
    assign cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign accept   = (cnt_inc >= {1'b0, neff});
    assign mismatch = (s_in != lvl);

    // ------------------------------------------------------------------
    // FSM, level, edge and interrupt registers.
    //
    // rise_q and fall_q mark the cycle in which lvl took a new value. edge_p
    // is registered from them, so the pulse appears one cycle after lvl
    // changes. The dis->stable reload writes lvl directly and never sets
    // these marks, so enabling the block cannot generate an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_dis;
            cnt      <= '0;
            lvl      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            edge_p   <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            edge_p <= (rise_q & edge_sel[0]) | (fall_q & edge_sel[1]);

            // A set beats a clear when both occur in the same cycle.
            if (edge_p) begin
                irq_flag <= 1'b1;
            end else if (clr) begin
                irq_flag <= 1'b0;
            end

            if (!en) begin
                // Leaving enable discards any pending change; lvl is held.
                state <= st_dis;
                cnt   <= '0;
            end else begin
                case (state)
                    st_dis: begin
                        lvl   <= s_in;
                        cnt   <= '0;
                        state <= st_stable;
                    end

                    st_stable: begin
                        if (tick && mismatch) begin
                            if (accept) begin
                                lvl    <= ~lvl;
                                rise_q <= ~lvl;
                                fall_q <= lvl;
                                cnt    <= '0;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= st_pend;
                            end
                        end
                    end

                    st_pend: begin
                        if (tick) begin
                            if (mismatch) begin
                                if (accept) begin
                                    lvl    <= ~lvl;
                                    rise_q <= ~lvl;
                                    fall_q <= lvl;
                                    cnt    <= '0;
                                    state  <= st_stable;
                                end else begin
                                    cnt <= cnt_inc[CNT_W-1:0];
                                end
                            end else begin
                                // Input went back to the accepted level:
                                // this was a glitch, so drop the count.
                                cnt   <= '0;
                                state <= st_stable;
                            end
                        end
                    end

                    default: begin
                        state <= st_dis;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;
    assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_nf_digital_filter_edge.sv
module tb_nf_digital_filter_edge;

    logic       clk;
    logic       rst;
    logic       en;
    logic       nfout_in;
    logic [7:0] prescale;
    logic [3:0] filt_n;
    logic [1:0] edge_sel;
    logic       clr;
    logic       lvl;
    logic       edge_p;
    logic       irq_flag;
    logic [1:0] state_dbg;
    logic [3:0] cnt_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    nf_digital_filter_edge #(
        .SYNC_STAGES(2),
        .PRE_W      (8),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .nfout_in (nfout_in),
        .prescale (prescale),
        .filt_n   (filt_n),
        .edge_sel (edge_sel),
        .clr      (clr),
        .lvl      (lvl),
        .edge_p   (edge_p),
        .irq_flag (irq_flag),
        .state_dbg(state_dbg),
        .cnt_dbg  (cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, required end before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        nfout_in = 1'b0;
        clr      = 1'b0;
        step();
        step();
        check("rst_lvl",   lvl,       0);
        check("rst_edge",  edge_p,    0);
        check("rst_irq",   irq_flag,  0);
        check("rst_state", state_dbg, 0);
        check("rst_cnt",   cnt_dbg,   0);
        rst = 1'b0;
    endtask

    // ---------------- latency vector table ----------------
    // In each vector, en=1 and nfout_in=1 are applied together straight after
    // reset. lat is the number of clock edges until lvl reads 1. Sample ticks
    // fall on edges k that are multiples of prescale+1, and s_in is first high
    // before edge 3.
    typedef struct {
        logic [7:0] ps;
        logic [3:0] fn;
        logic [1:0] es;
        int         lat;
        logic       exp_edge;
    } lat_vec_t;

    lat_vec_t vecs[7];

    // scoreboard of expected edge_p cycles for the prescaled toggle sequence
    logic [31:0] exp_q[$];

    initial begin
        int k;
        logic got;
        int rise_k;
        int fall_k;
        int pulses;
        logic prev_lvl;
        logic seen_hi;
        logic seen_edge;
        logic [31:0] exp_cyc;

        vecs[0] = '{ps: 8'd0, fn: 4'd0,  es: 2'b01, lat: 3,  exp_edge: 1'b1};
        vecs[1] = '{ps: 8'd0, fn: 4'd1,  es: 2'b10, lat: 3,  exp_edge: 1'b0};
        vecs[2] = '{ps: 8'd0, fn: 4'd3,  es: 2'b01, lat: 5,  exp_edge: 1'b1};
        vecs[3] = '{ps: 8'd4, fn: 4'd2,  es: 2'b11, lat: 10, exp_edge: 1'b1};
        vecs[4] = '{ps: 8'd1, fn: 4'd1,  es: 2'b00, lat: 4,  exp_edge: 1'b0};
        vecs[5] = '{ps: 8'd2, fn: 4'd4,  es: 2'b11, lat: 12, exp_edge: 1'b1};
        vecs[6] = '{ps: 8'd0, fn: 4'd15, es: 2'b01, lat: 17, exp_edge: 1'b1};

        rst = 1'b1; en = 1'b0; nfout_in = 1'b0; clr = 1'b0;
        prescale = '0; filt_n = '0; edge_sel = '0;

        // ---- table: rise latency, edge qualification, irq ----
        for (int i = 0; i < 7; i++) begin
            do_reset();
            prescale = vecs[i].ps;
            filt_n   = vecs[i].fn;
            edge_sel = vecs[i].es;
            en       = 1'b1;
            nfout_in = 1'b1;
            k   = 0;
            got = 1'b0;
            while (k < 100 && !got) begin
                step();
                k++;
                if (lvl) got = 1'b1;
            end
            check("vec_latency", k, vecs[i].lat);
            step();
            check("vec_edge", edge_p, vecs[i].exp_edge);
            step();
            check("vec_edge_single", edge_p, 0);
            check("vec_irq", irq_flag, vecs[i].exp_edge);
        end

        // ---- glitch shorter than filt_n is rejected ----
        do_reset();
        prescale = 8'd0; filt_n = 4'd3; edge_sel = 2'b11; en = 1'b1; nfout_in = 1'b0;
        repeat (4) step();
        check("glitch_pre_state", state_dbg, 1);
        seen_hi = 1'b0; seen_edge = 1'b0;
        nfout_in = 1'b1;
        step(); step();
        nfout_in = 1'b0;
        step();
        check("glitch_cnt1", cnt_dbg, 1);
        check("glitch_pend", state_dbg, 2);
        step();
        check("glitch_cnt2", cnt_dbg, 2);
        step();
        check("glitch_cnt0", cnt_dbg, 0);
        check("glitch_stable", state_dbg, 1);
        for (int j = 0; j < 12; j++) begin
            step();
            if (lvl) seen_hi = 1'b1;
            if (edge_p) seen_edge = 1'b1;
        end
        check("glitch_lvl", seen_hi, 0);
        check("glitch_edge", seen_edge, 0);
        check("glitch_irq", irq_flag, 0);

        // ---- prescaled toggle, both edges, edges land on ticks ----
        do_reset();
        prescale = 8'd4; filt_n = 4'd2; edge_sel = 2'b11; en = 1'b1; nfout_in = 1'b1;
        exp_q.push_back(32'd11);
        exp_q.push_back(32'd51);
        rise_k = -1; fall_k = -1; pulses = 0; prev_lvl = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            step();
            if (lvl && !prev_lvl) rise_k = j;
            if (!lvl && prev_lvl) fall_k = j;
            prev_lvl = lvl;
            if (edge_p) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    exp_cyc = exp_q.pop_front();
                    check("toggle_edge_cycle", j, exp_cyc);
                end else begin
                    check("toggle_extra_edge", j, 0);
                end
            end
            if (j == 40) nfout_in = 1'b0;
        end
        check("toggle_rise_cycle", rise_k, 10);
        check("toggle_fall_cycle", fall_k, 50);
        check("toggle_pulses", pulses, 2);
        check("toggle_lvl_end", lvl, 0);
        check("toggle_irq", irq_flag, 1);

        // ---- falling-only select, clr coincident with edge_p ----
        do_reset();
        prescale = 8'd0; filt_n = 4'd1; edge_sel = 2'b10; en = 1'b1; nfout_in = 1'b1;
        step(); step(); step();
        check("fall_rise_lvl", lvl, 1);
        step();
        check("fall_rise_no_edge", edge_p, 0);
        check("fall_rise_no_irq", irq_flag, 0);
        nfout_in = 1'b0;
        step(); step(); step();
        check("fall_lvl", lvl, 0);
        step();
        check("fall_edge", edge_p, 1);
        clr = 1'b1;
        step();
        check("clr_with_edge_irq", irq_flag, 1);
        check("fall_edge_single", edge_p, 0);
        step();
        check("clr_alone_irq", irq_flag, 0);
        clr = 1'b0;

        // ---- enable behaviour: reload without edge, drop in pend ----
        do_reset();
        prescale = 8'd0; filt_n = 4'd3; edge_sel = 2'b11; en = 1'b0; nfout_in = 1'b1;
        repeat (4) step();
        check("dis_lvl_held", lvl, 0);
        check("dis_state", state_dbg, 0);
        en = 1'b1;
        step();
        check("en_reload_lvl", lvl, 1);
        check("en_reload_state", state_dbg, 1);
        step();
        check("en_reload_no_edge", edge_p, 0);
        step();
        check("en_reload_no_edge2", edge_p, 0);
        check("en_reload_no_irq", irq_flag, 0);
        nfout_in = 1'b0;
        step(); step(); step();
        check("en_pend_state", state_dbg, 2);
        check("en_pend_cnt", cnt_dbg, 1);
        en = 1'b0;
        step();
        check("en_drop_state", state_dbg, 0);
        check("en_drop_cnt", cnt_dbg, 0);
        check("en_drop_lvl", lvl, 1);
        seen_edge = 1'b0; got = 1'b0;
        repeat (4) begin
            step();
            if (edge_p) seen_edge = 1'b1;
            if (!lvl) got = 1'b1;
        end
        check("en_drop_no_edge", seen_edge, 0);
        check("en_drop_lvl_kept", got, 0);

        // ---- reset while pending with lvl=1 ----
        do_reset();
        prescale = 8'd0; filt_n = 4'd3; edge_sel = 2'b11; en = 1'b1; nfout_in = 1'b1;
        repeat (5) step();
        check("rp_lvl", lvl, 1);
        step();
        check("rp_edge", edge_p, 1);
        step();
        check("rp_irq", irq_flag, 1);
        nfout_in = 1'b0;
        step(); step(); step();
        check("rp_pend", state_dbg, 2);
        rst = 1'b1;
        step();
        check("rp_rst_lvl", lvl, 0);
        check("rp_rst_edge", edge_p, 0);
        check("rp_rst_irq", irq_flag, 0);
        check("rp_rst_state", state_dbg, 0);
        check("rp_rst_cnt", cnt_dbg, 0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
